// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin sharing of one spi_master between NUM_REQ requesters.
// Optional transfer watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_master_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_XFER_SIZE = 32,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int XFER_CNT_WIDTH = $clog2(MAX_XFER_SIZE)
) (
  input  logic                              i_sys_clk,
  input  logic                              i_sys_rst_n,
  input  logic [NUM_REQ-1:0]                i_req_valid,
  input  logic [NUM_REQ*MAX_XFER_SIZE-1:0]  i_req_data,
  input  logic [NUM_REQ*XFER_CNT_WIDTH-1:0] i_req_size,
  output logic [NUM_REQ-1:0]                o_req_ack,
  output logic [MAX_XFER_SIZE-1:0]          o_rsp_data,
  output logic [NUM_REQ-1:0]                o_rsp_valid,
  output logic                              o_rsp_err,
  output logic                              o_busy,
  output logic [MAX_XFER_SIZE-1:0]          o_piso_data,
  output logic [XFER_CNT_WIDTH-1:0]         o_piso_xfer_size,
  output logic                              o_piso_req,
  input  logic                              i_piso_ack,
  input  logic [MAX_XFER_SIZE-1:0]          i_sipo_data,
  input  logic                              i_sipo_rdy
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESPOND} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, last_grant_q, last_grant_d, sel;
  logic found;
  logic [MAX_XFER_SIZE-1:0] piso_data_q, piso_data_d, rsp_data_q, rsp_data_d;
  logic [XFER_CNT_WIDTH-1:0] piso_size_q, piso_size_d;
  logic piso_req_q, piso_req_d, busy_q, busy_d;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_d, rsp_valid_q, rsp_valid_d;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic rsp_err_q, rsp_err_d;
`endif
  // Round-robin search starting just above the previous grant.
  always_comb begin
    found = 1'b0;
    sel = last_grant_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && i_req_valid[IW'((int'(last_grant_q) + i) % NUM_REQ)]) begin
        found = 1'b1;
        sel = IW'((int'(last_grant_q) + i) % NUM_REQ);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_grant_d = last_grant_q;
    piso_data_d = piso_data_q;
    piso_size_d = piso_size_q;
    piso_req_d = piso_req_q;
    rsp_data_d = rsp_data_q;
    req_ack_d = '0;
    rsp_valid_d = '0;
    case (state_q)
      IDLE: if (found) begin
        state_d = ISSUE;
        grant_d = sel;
        piso_data_d = i_req_data[int'(sel)*MAX_XFER_SIZE +: MAX_XFER_SIZE];
        piso_size_d = i_req_size[int'(sel)*XFER_CNT_WIDTH +: XFER_CNT_WIDTH];
        piso_req_d = 1'b1;
        req_ack_d[sel] = 1'b1;
      end
      ISSUE: if (i_piso_ack) begin
        piso_req_d = 1'b0;
        state_d = i_sipo_rdy ? RESPOND : WAIT_DONE;
        rsp_data_d = i_sipo_rdy ? i_sipo_data : rsp_data_q;
        rsp_valid_d[grant_q] = i_sipo_rdy;
      end
      WAIT_DONE: if (i_sipo_rdy) begin
        state_d = RESPOND;
        rsp_data_d = i_sipo_data;
        rsp_valid_d[grant_q] = 1'b1;
      end
      default: begin
        last_grant_d = grant_q;
        state_d = IDLE;
      end
    endcase
`ifdef SPI_ARB_TIMEOUT_EN
    rsp_err_d = 1'b0;
    cnt_d = (state_q == ISSUE || state_q == WAIT_DONE) ? cnt_q + 1'b1 : '0;
    // A real completion on the expiry cycle wins over the watchdog.
    if ((state_q == ISSUE || state_q == WAIT_DONE) && cnt_q == CW'(TIMEOUT_CYCLES - 1) && state_d != RESPOND) begin
      state_d = RESPOND;
      piso_req_d = 1'b0;
      rsp_valid_d = '0;
      rsp_valid_d[grant_q] = 1'b1;
      rsp_err_d = 1'b1;
    end
`endif
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_grant_q <= IW'(NUM_REQ - 1);
      piso_data_q <= '0;
      piso_size_q <= '0;
      piso_req_q <= 1'b0;
      rsp_data_q <= '0;
      req_ack_q <= '0;
      rsp_valid_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_grant_q <= last_grant_d;
      piso_data_q <= piso_data_d;
      piso_size_q <= piso_size_d;
      piso_req_q <= piso_req_d;
      rsp_data_q <= rsp_data_d;
      req_ack_q <= req_ack_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q <= busy_d;
    end
  end
`ifdef SPI_ARB_TIMEOUT_EN
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      cnt_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign o_rsp_err = rsp_err_q;
`else
  assign o_rsp_err = 1'b0;
`endif
  assign o_req_ack = req_ack_q;
  assign o_rsp_data = rsp_data_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_busy = busy_q;
  assign o_piso_data = piso_data_q;
  assign o_piso_xfer_size = piso_size_q;
  assign o_piso_req = piso_req_q;
endmodule
